// File: rtl/quant_write_coalescer_if.sv
// SRAM-C write/read request bus shared by the quantization side and the SRAM side.
//   wdata : write data (SRAMC_W bits)
//   addr  : SRAM word address
//   wren  : write request / strobe
//   wmask : granule mask, index k covers wdata[(SRAMC_N-1-k)*G +: G]
//   rden  : read request / strobe
// master drives the bus, slave receives it.
interface quant_write_coalescer_if #(
  parameter int SRAMC_W = 128,
  parameter int ADRC_W  = 11,
  parameter int SRAMC_N = 8
);
  logic [SRAMC_W-1:0] wdata;
  logic [ADRC_W-1:0]  addr;
  logic               wren;
  logic [0:SRAMC_N-1] wmask;
  logic               rden;

  modport master (output wdata, addr, wren, wmask, rden);
  modport slave  (input  wdata, addr, wren, wmask, rden);
endinterface

// File: rtl/quant_write_coalescer.sv
// Merges consecutive partial writes to the same SRAM word into a single
// full-mask write, orders reads against the pending merge entry and keeps the
// single-port SRAM at one transaction per cycle. All SRAM outputs registered.
//   i_clk, i_rstn : clock, synchronous active-low reset
//   i_sramc       : requests from quantization (slave)
//   i_flush       : pulse, write out the pending entry
//   o_ready       : input accepted this cycle
//   o_sramc       : transactions to the SRAM (master)
//   o_idle        : nothing pending, skid empty, no flush request
//   o_err         : sticky, wren and rden both high on an accepted cycle
module quant_write_coalescer #(
  parameter int SRAMC_W = 128,
  parameter int ADRC_W  = 11,
  parameter int SRAMC_N = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  quant_write_coalescer_if.slave  i_sramc,
  input  logic                   i_flush,
  output logic                   o_ready,
  quant_write_coalescer_if.master o_sramc,
  output logic                   o_idle,
  output logic                   o_err
);
  localparam int unsigned N  = SRAMC_N;
  localparam int unsigned G  = SRAMC_W / SRAMC_N;
  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT);

  typedef enum logic [1:0] {TX_NONE, TX_WRITE, TX_READ} tx_e;

  logic               pend_v, pend_v_n;
  logic [ADRC_W-1:0]  pend_addr, pend_addr_n;
  logic [SRAMC_W-1:0] pend_data, pend_data_n;
  logic [0:SRAMC_N-1] pend_mask, pend_mask_n;
  logic               skid_v, skid_v_n;
  logic [ADRC_W-1:0]  skid_addr, skid_addr_n;
  logic               flush_req, flush_req_n;
  logic [TW-1:0]      tcnt, tcnt_n;
  logic               err, err_n;

  logic               acc_wr, acc_rd, hit, timeout_hit;
  logic [SRAMC_W-1:0] m_data;
  logic [0:SRAMC_N-1] m_mask;

  tx_e                tx;
  logic [ADRC_W-1:0]  tx_addr;
  logic [SRAMC_W-1:0] tx_data;
  logic [0:SRAMC_N-1] tx_mask;

  assign o_ready = i_rstn & ~skid_v;
  assign o_idle  = ~i_rstn | (~pend_v & ~skid_v & ~flush_req);
  assign o_err   = err;

  always_comb begin
    acc_wr      = o_ready & i_sramc.wren;
    acc_rd      = o_ready & i_sramc.rden & ~i_sramc.wren;
    hit         = pend_v & (i_sramc.addr == pend_addr);
    timeout_hit = (TIMEOUT != 0) && (tcnt >= TLIM);

    m_mask = pend_mask | i_sramc.wmask;
    m_data = pend_data;
    for (int unsigned k = 0; k < N; k++) begin
      if (i_sramc.wmask[k]) m_data[(N-1-k)*G +: G] = i_sramc.wdata[(N-1-k)*G +: G];
    end

    pend_v_n    = pend_v;
    pend_addr_n = pend_addr;
    pend_data_n = pend_data;
    pend_mask_n = pend_mask;
    skid_v_n    = skid_v;
    skid_addr_n = skid_addr;
    tcnt_n      = tcnt;
    flush_req_n = flush_req | (i_flush & pend_v);
    err_n       = err | (o_ready & i_sramc.wren & i_sramc.rden);

    tx      = TX_NONE;
    tx_addr = '0;
    tx_data = '0;
    tx_mask = '0;

    if (skid_v) begin
      // Second half of a read hazard: the pending write already went out.
      tx       = TX_READ;
      tx_addr  = skid_addr;
      skid_v_n = 1'b0;
    end else if (acc_wr && !pend_v) begin
      pend_v_n    = 1'b1;
      pend_addr_n = i_sramc.addr;
      pend_data_n = i_sramc.wdata;
      pend_mask_n = i_sramc.wmask;
      tcnt_n      = '0;
    end else if (acc_wr && hit) begin
      tcnt_n      = '0;
      pend_data_n = m_data;
      pend_mask_n = m_mask;
      // A full merge goes out now; a partial merge leaves the port free, so
      // an already-registered flush request drains the merged entry instead.
      if ((&m_mask) || flush_req) begin
        tx       = TX_WRITE;
        tx_addr  = pend_addr;
        tx_data  = m_data;
        tx_mask  = m_mask;
        pend_v_n = 1'b0;
      end
    end else if (acc_wr) begin
      tx          = TX_WRITE;
      tx_addr     = pend_addr;
      tx_data     = pend_data;
      tx_mask     = pend_mask;
      pend_addr_n = i_sramc.addr;
      pend_data_n = i_sramc.wdata;
      pend_mask_n = i_sramc.wmask;
      tcnt_n      = '0;
      flush_req_n = 1'b0;
    end else if (acc_rd && hit) begin
      tx          = TX_WRITE;
      tx_addr     = pend_addr;
      tx_data     = pend_data;
      tx_mask     = pend_mask;
      pend_v_n    = 1'b0;
      skid_v_n    = 1'b1;
      skid_addr_n = i_sramc.addr;
    end else if (acc_rd) begin
      tx      = TX_READ;
      tx_addr = i_sramc.addr;
      if (pend_v && tcnt != TLIM) tcnt_n = tcnt + 1'b1;
    end else if (pend_v) begin
      if (flush_req || timeout_hit) begin
        tx       = TX_WRITE;
        tx_addr  = pend_addr;
        tx_data  = pend_data;
        tx_mask  = pend_mask;
        pend_v_n = 1'b0;
      end else if (tcnt != TLIM) begin
        tcnt_n = tcnt + 1'b1;
      end
    end

    if (!pend_v_n) flush_req_n = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      pend_v        <= 1'b0;
      pend_addr     <= '0;
      pend_data     <= '0;
      pend_mask     <= '0;
      skid_v        <= 1'b0;
      skid_addr     <= '0;
      flush_req     <= 1'b0;
      tcnt          <= '0;
      err           <= 1'b0;
      o_sramc.wren  <= 1'b0;
      o_sramc.rden  <= 1'b0;
      o_sramc.addr  <= '0;
      o_sramc.wdata <= '0;
      o_sramc.wmask <= '0;
    end else begin
      pend_v        <= pend_v_n;
      pend_addr     <= pend_addr_n;
      pend_data     <= pend_data_n;
      pend_mask     <= pend_mask_n;
      skid_v        <= skid_v_n;
      skid_addr     <= skid_addr_n;
      flush_req     <= flush_req_n;
      tcnt          <= tcnt_n;
      err           <= err_n;
      o_sramc.wren  <= (tx == TX_WRITE);
      o_sramc.rden  <= (tx == TX_READ);
      o_sramc.addr  <= tx_addr;
      o_sramc.wdata <= tx_data;
      o_sramc.wmask <= tx_mask;
    end
  end
endmodule

// File: tb/tb_quant_write_coalescer.sv
// Bench for quant_write_coalescer: directed scenarios with literal expectations
// followed by randomized traffic, all checked each cycle against a lane-level
// behavioural model.
module tb_quant_write_coalescer;
  localparam int W  = 128;
  localparam int AW = 11;
  localparam int N  = 8;
  localparam int G  = W / N;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic ready, idle, err;

  quant_write_coalescer_if #(.SRAMC_W(W), .ADRC_W(AW), .SRAMC_N(N)) up_if ();
  quant_write_coalescer_if #(.SRAMC_W(W), .ADRC_W(AW), .SRAMC_N(N)) dn_if ();

  quant_write_coalescer #(.SRAMC_W(W), .ADRC_W(AW), .SRAMC_N(N), .TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .i_sramc(up_if),
    .i_flush(flush),
    .o_ready(ready),
    .o_sramc(dn_if),
    .o_idle (idle),
    .o_err  (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  bit            m_pv = 0, m_skid = 0, m_freq = 0, m_err = 0;
  logic [AW-1:0] m_paddr = '0, m_saddr = '0;
  logic [G-1:0]  m_lane [N];
  bit            m_lmask [N];
  int            m_age = 0;
  logic          e_wren = 0, e_rden = 0;
  logic [AW-1:0] e_addr = '0;
  logic [W-1:0]  e_data = '0;
  logic [0:N-1]  e_mask = '0;

  task automatic emit_pend();
    e_wren = 1'b1;
    e_addr = m_paddr;
    for (int k = 0; k < N; k++) begin
      e_data[(N-1-k)*G +: G] = m_lane[k];
      e_mask[k] = m_lmask[k];
    end
  endtask

  task automatic load_in();
    m_pv = 1;
    m_paddr = up_if.addr;
    m_age = 0;
    for (int k = 0; k < N; k++) begin
      m_lane[k] = up_if.wdata[(N-1-k)*G +: G];
      m_lmask[k] = up_if.wmask[k];
    end
  endtask

  always @(posedge clk) begin : model_step
    bit wr, rd, hit, fq, full;
    e_wren = 0; e_rden = 0; e_addr = '0; e_data = '0; e_mask = '0;
    if (!rstn) begin
      m_pv = 0; m_skid = 0; m_freq = 0; m_err = 0; m_age = 0;
    end else begin
      wr  = !m_skid && up_if.wren;
      rd  = !m_skid && up_if.rden && !up_if.wren;
      if (wr && up_if.rden) m_err = 1;
      hit = m_pv && (up_if.addr == m_paddr);
      fq  = m_freq;
      if (flush && m_pv) m_freq = 1;
      if (m_skid) begin
        e_rden = 1; e_addr = m_saddr; m_skid = 0;
      end else if (wr && !m_pv) begin
        load_in();
      end else if (wr && hit) begin
        full = 1;
        for (int k = 0; k < N; k++) begin
          if (up_if.wmask[k]) begin
            m_lane[k] = up_if.wdata[(N-1-k)*G +: G];
            m_lmask[k] = 1;
          end
          full &= m_lmask[k];
        end
        m_age = 0;
        if (full || fq) begin emit_pend(); m_pv = 0; end
      end else if (wr) begin
        emit_pend(); m_freq = 0; load_in();
      end else if (rd && hit) begin
        emit_pend(); m_pv = 0; m_skid = 1; m_saddr = up_if.addr;
      end else if (rd) begin
        e_rden = 1; e_addr = up_if.addr;
        if (m_pv) m_age++;
      end else if (m_pv) begin
        if (fq || (TO != 0 && m_age >= TO)) begin emit_pend(); m_pv = 0; end
        else m_age++;
      end
      if (!m_pv) m_freq = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dn_if.wren !== e_wren || dn_if.rden !== e_rden || dn_if.addr !== e_addr ||
          dn_if.wmask !== e_mask || dn_if.wdata !== e_data) begin
        errors++;
        $display("FAIL txn t=%0t got wr=%b rd=%b a=%h m=%h d=%h want wr=%b rd=%b a=%h m=%h d=%h",
                 $time, dn_if.wren, dn_if.rden, dn_if.addr, dn_if.wmask, dn_if.wdata,
                 e_wren, e_rden, e_addr, e_mask, e_data);
      end
      checks++;
      if (ready !== (rstn && !m_skid) || idle !== (!rstn || !(m_pv || m_skid || m_freq)) ||
          err !== m_err) begin
        errors++;
        $display("FAIL status t=%0t got rdy=%b idle=%b err=%b want rdy=%b idle=%b err=%b",
                 $time, ready, idle, err, rstn && !m_skid,
                 !rstn || !(m_pv || m_skid || m_freq), m_err);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit wr, input bit rd, input int a, input logic [7:0] m,
                        input logic [7:0] lane);
    up_if.wren  = wr;
    up_if.rden  = rd;
    up_if.addr  = AW'(a);
    up_if.wmask = m;
    up_if.wdata = {16{lane}};
    flush       = 1'b0;
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 8'h00, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, cnt, gap;
    logic [7:0] mtab [4];
    mtab[0] = 8'h03; mtab[1] = 8'h0C; mtab[2] = 8'h30; mtab[3] = 8'hC0;

    idle_in();
    rstn = 1'b0;
    cycle();
    chk_en = 1'b1;
    cycle();
    chk("rst_ready", W'(ready), W'(0));
    chk("rst_idle", W'(idle), W'(1));
    chk("rst_wren", W'(dn_if.wren), W'(0));
    rstn = 1'b1;

    // Four partial writes to one word merge into one full write.
    set_in(1, 0, 5, 8'h03, 8'h11); cycle(); chk("merge_early0", W'(dn_if.wren), W'(0));
    set_in(1, 0, 5, 8'h0C, 8'h22); cycle(); chk("merge_early1", W'(dn_if.wren), W'(0));
    set_in(1, 0, 5, 8'h30, 8'h33); cycle(); chk("merge_early2", W'(dn_if.wren), W'(0));
    set_in(1, 0, 5, 8'hC0, 8'h44); cycle();
    chk("merge_wren", W'(dn_if.wren), W'(1));
    chk("merge_addr", W'(dn_if.addr), W'(5));
    chk("merge_mask", W'(dn_if.wmask), W'(8'hFF));
    chk("merge_data", dn_if.wdata, 128'h44444444_33333333_22222222_11111111);
    idle_in(); cycle(); chk("merge_after", W'(dn_if.wren), W'(0));

    // Address change evicts the partial entry; explicit flush drains the new one.
    set_in(1, 0, 5, 8'h03, 8'hAA); cycle();
    set_in(1, 0, 6, 8'h0C, 8'hBB); cycle();
    chk("evict_addr", W'(dn_if.addr), W'(5));
    chk("evict_mask", W'(dn_if.wmask), W'(8'h03));
    chk("evict_data", dn_if.wdata, {16{8'hAA}});
    chk("evict_idle", W'(idle), W'(0));
    idle_in(); flush = 1'b1; cycle(); chk("flush_wait", W'(dn_if.wren), W'(0));
    flush = 1'b0; cycle();
    chk("flush_wren", W'(dn_if.wren), W'(1));
    chk("flush_addr", W'(dn_if.addr), W'(6));
    chk("flush_mask", W'(dn_if.wmask), W'(8'h0C));

    // Read hazard on the pending word.
    set_in(1, 0, 7, 8'h03, 8'h55); cycle();
    set_in(0, 1, 7, 8'h00, 8'h00); cycle();
    chk("haz_wr", W'({dn_if.wren, dn_if.rden, dn_if.addr, dn_if.wmask}), W'({2'b10, 11'h7, 8'h03}));
    chk("haz_stall", W'(ready), W'(0));
    idle_in(); cycle();
    chk("haz_rd", W'({dn_if.wren, dn_if.rden, dn_if.addr, dn_if.wmask}), W'({2'b01, 11'h7, 8'h00}));
    chk("haz_rd_data", dn_if.wdata, W'(0));
    chk("haz_ready", W'(ready), W'(1));

    // Read to another word passes the pending entry.
    set_in(1, 0, 7, 8'h03, 8'h66); cycle();
    set_in(0, 1, 9, 8'h00, 8'h00); cycle();
    chk("pass_rd", W'({dn_if.wren, dn_if.rden, dn_if.addr}), W'({2'b01, 11'h9}));
    chk("pass_ready", W'(ready), W'(1));
    chk("pass_idle", W'(idle), W'(0));
    idle_in(); flush = 1'b1; cycle(); flush = 1'b0; cycle();
    chk("pass_drain", W'({dn_if.wren, dn_if.addr}), W'({1'b1, 11'h7}));

    // Timeout: single write, then idle.
    set_in(1, 0, 2, 8'h30, 8'h77); cycle();
    idle_in();
    first = -1;
    for (int k = 1; k <= 40 && first < 0; k++) begin
      cycle();
      if (dn_if.wren === 1'b1) first = k;
    end
    chk("timeout_lat", W'(first), W'(TO + 1));
    chk("timeout_mask", W'(dn_if.wmask), W'(8'h30));

    // Reset with an entry pending: nothing comes out afterwards.
    set_in(1, 0, 11, 8'h0C, 8'h12); cycle();
    idle_in(); rstn = 1'b0; cycle();
    chk("rstp_out", W'({dn_if.wren, dn_if.rden}), W'(0));
    rstn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      cycle();
      if (dn_if.wren === 1'b1 || dn_if.rden === 1'b1) cnt++;
    end
    chk("rstp_quiet", W'(cnt), W'(0));

    // Reset with the skid full.
    set_in(1, 0, 10, 8'h03, 8'h34); cycle();
    set_in(0, 1, 10, 8'h00, 8'h00); cycle();
    idle_in(); rstn = 1'b0; cycle();
    chk("rsts_out", W'({dn_if.wren, dn_if.rden, ready}), W'(0));
    rstn = 1'b1; cycle();
    chk("rsts_rd", W'({dn_if.wren, dn_if.rden}), W'(0));
    chk("rsts_err", W'(err), W'(0));

    // wren and rden together: write only, sticky error.
    set_in(1, 1, 3, 8'h03, 8'h9C); cycle();
    chk("both_err", W'(err), W'(1));
    chk("both_noout", W'({dn_if.wren, dn_if.rden}), W'(0));
    idle_in(); flush = 1'b1; cycle(); flush = 1'b0; cycle();
    chk("both_wr", W'({dn_if.wren, dn_if.rden, dn_if.addr}), W'({2'b10, 11'h3}));
    chk("both_sticky", W'(err), W'(1));

    // Randomized traffic.
    gap = 0;
    for (int c = 0; c < 3000; c++) begin
      cycle();
      flush = ($urandom_range(0, 24) == 0);
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 499) == 0) rstn = 1'b0;
      if (rstn && !ready) begin
        // hold the request until it is accepted
      end else if (gap > 0) begin
        gap--;
        up_if.wren = 0; up_if.rden = 0;
      end else begin
        if ($urandom_range(0, 99) == 0) gap = $urandom_range(5, 22);
        case ($urandom_range(0, 31))
          0:                                 begin up_if.wren = 1; up_if.rden = 1; end
          1, 2, 3, 4, 5, 6, 7, 8:            begin up_if.wren = 0; up_if.rden = 1; end
          9, 10, 11, 12, 13, 14:             begin up_if.wren = 0; up_if.rden = 0; end
          default:                           begin up_if.wren = 1; up_if.rden = 0; end
        endcase
        up_if.addr  = AW'($urandom_range(16, 19));
        up_if.wmask = ($urandom_range(0, 9) == 0) ? 8'($urandom()) : mtab[$urandom_range(0, 3)];
        up_if.wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
    end
    idle_in();
    rstn = 1'b1;
    for (int k = 0; k < 30; k++) cycle();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/quant_write_coalescer.md
Name: quant_write_coalescer

Overview:
Sits directly downstream of the quantization stage and upstream of the SRAMC write port. Quantization emits one narrow partial write per 32-bit-lane group, with a replicated data pattern and a positioned mask (0x03/0x0C/0x30/0xC0 at word address addr>>2). This block merges consecutive partial writes to the same SRAM word into a single full-mask write. It also orders reads against the pending merge buffer and keeps the single-port SRAM at one transaction per cycle.

Parameters:
SRAMC_W, 128, SRAM data width
ADRC_W, 11, SRAM word address width
SRAMC_N, 8, mask granules per word; granule width G = SRAMC_W/SRAMC_N (16)
TIMEOUT, 16, cycles a pending entry may sit unmerged before auto-flush; 0 disables auto-flush

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  synchronous active-low reset, sampled on i_clk rising edge
i_sramc_wdata  in  SRAMC_W  write data from quantization
i_sramc_addr  in  ADRC_W  word address (already divided by 4)
i_sramc_wren  in  1  write request
i_sramc_wmask  in  [0:SRAMC_N-1]  granule mask; index k covers data bits [(SRAMC_N-1-k)*G +: G]
i_sramc_rden  in  1  read request
i_flush  in  1  pulse: write out pending entry
o_ready  out  1  input accepted this cycle when 1; o_ready = i_rstn & ~skid_v (combinational)
o_sramc_wdata  out  SRAMC_W  merged write data to SRAM
o_sramc_addr  out  ADRC_W  SRAM address
o_sramc_wren  out  1  SRAM write strobe
o_sramc_wmask  out  [0:SRAMC_N-1]  SRAM mask
o_sramc_rden  out  1  SRAM read strobe
o_idle  out  1  pending empty, skid empty, no flush request
o_err  out  1  sticky: wren and rden both high on an accepted cycle

Behaviour:
- State: pending entry {pend_v, pend_addr, pend_data, pend_mask}; read skid {skid_v, skid_addr}; flush_req; timeout counter tcnt.
- All SRAM outputs are registered. An output transaction appears the cycle after the decision. Idle outputs: wren=rden=0 and data/addr/mask=0. Read transactions drive wmask=0 and wdata=0.
- Reset (i_rstn=0 at an edge): all outputs 0 and o_err=0. pend_v, skid_v, flush_req and tcnt are cleared, and pending data is discarded. While i_rstn=0, o_ready=0 and o_idle=1.
- Inputs are sampled only when o_ready=1. When o_ready=0, upstream holds its request.
- Port priority each cycle: (1) skid read, (2) emission caused by the accepted input, (3) flush_req/timeout flush. At most one SRAM transaction per cycle.
- Accepted write, pend_v=0: load the pending entry with data/mask as given; no output.
- Accepted write, pend_v=1, same addr:
  - Merge: for each granule k with mask[k]=1, take the input granule; OR the masks.
  - If the merged mask is all ones, emit the merged write and clear pend_v; otherwise keep it pending.
  - tcnt resets to 0.
- Accepted write, pend_v=1, different addr: emit the old pending entry as-is (partial mask allowed), then load the new entry.
- Accepted read, addr != pend_addr or pend_v=0: emit the read next cycle; pending is untouched and tcnt keeps counting.
- Accepted read, addr == pend_addr with pend_v=1 (hazard):
  - Emit the pending write next cycle, clear pend_v, and load the skid; o_ready=0 for that cycle.
  - The following cycle emits the read and clears the skid.
  - Read-after-write ordering is guaranteed.
- wren and rden both high: treated as a write, rden ignored, o_err set (sticky until reset).
- i_flush: sets flush_req if pend_v=1, else ignored.
- Flush path: when flush_req is set, or TIMEOUT≠0 and tcnt reaches TIMEOUT, and the port is free, emit the pending entry and clear pend_v and flush_req.
  - If the port is busy, the flush waits.
  - If pending is evicted or completed by the input path, flush_req clears.
- tcnt: increments each cycle pend_v=1 with no merge into the entry; cleared on load/merge.
- Timeout latency: with no further activity, a pending entry loaded or last merged at edge T appears on the output at T+TIMEOUT+1.

Test Plan:
- Writes to addr 0x05 with masks 0x03, 0x0C, 0x30, 0xC0 and data lanes 0x11/0x22/0x33/0x44 on 4 consecutive cycles -> exactly one write, addr 0x05, mask 0xFF, the cycle after the 4th input; no earlier wren.
- Write addr 0x05 mask 0x03, then write addr 0x06 mask 0x0C -> write addr 0x05 mask 0x03 emitted the next cycle; 0x06 held pending; o_idle=0.
- Write addr 0x07 mask 0x03, then read addr 0x07 -> write 0x07/0x03 at T+1 with o_ready=0, read 0x07 at T+2, o_ready=1 at T+2.
- Read addr 0x09 while 0x07 is pending -> rden addr 0x09 the next cycle; 0x07 still pending; no stall.
- TIMEOUT=16, single write addr 0x02 mask 0x30, then idle -> write emitted exactly 17 cycles after acceptance; i_flush variant emits it 2 cycles after the pulse.
- Assert i_rstn=0 with an entry pending and skid full -> outputs 0 the next edge; nothing written after release; wren+rden together after release -> o_err=1 and a write only.
